alu_result_accum: RTL and testbench

//  Downstream consumer of the 8-bit signed ALU's registered 16-bit result.

---
 rtl/alu_result_accum_if.sv | 47 ++++
 rtl/alu_result_accum.sv | 156 +++++++++++++++
 tb/tb_alu_result_accum.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_accum_if.sv
// ----------------------------------------------------------------------------
// alu_result_accum_if
//   Bundles the input-side and output-side valid/ready handshakes of the
//   ALU block-sum accumulator.
//
//   Handshake rule (both sides):
//     A beat moves on a rising clock edge where valid & ready are both high.
//     The producer holds valid and its data stable until that edge.
//     The consumer may drive ready without looking at valid.
//
//   Signals
//     in_valid  producer -> accum   in_data holds a valid ALU result
//     in_data   producer -> accum   signed ALU result (IN_W bits)
//     in_ready  accum -> producer   accumulator can take in_data
//     flush     producer -> accum   close the current partial block
//     out_valid accum -> sink       block sum available
//     out_ready sink -> accum       sink takes the block sum
//     out_data  accum -> sink       signed, saturated block sum (ACC_W bits)
//     out_count accum -> sink       number of results in the block
//     out_sat   accum -> sink       saturation happened inside the block
//
//   Modports: master = producer/sink side, slave = accumulator side.
// ----------------------------------------------------------------------------
interface alu_result_accum_if #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 18
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic                    in_ready;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic [3:0]              out_count;
    logic                    out_sat;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface

// File: rtl/alu_result_accum.sv
// ----------------------------------------------------------------------------
// alu_result_accum
//   Sums blocks of BLOCK_LEN signed ALU results into a saturating accumulator
//   and presents each block sum on a valid/ready output. A flush closes a
//   partial block early. While a sum is held for the sink, input is stalled.
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-low reset
//     bus        alu_result_accum_if.slave (input/output handshakes)
//     dbg_state  current FSM state (0 idle, 1 accumulating, 2 holding)
//
//   Parameters
//     IN_W       signed input width (must match the interface)
//     ACC_W      signed accumulator/output width, >= IN_W+1
//     BLOCK_LEN  results per block, 2..15
// ----------------------------------------------------------------------------
module alu_result_accum #(
    parameter int IN_W      = 16,
    parameter int ACC_W     = 18,
    parameter int BLOCK_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_accum_if.slave  bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    localparam logic signed [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [3:0]              BLOCK_LEN_C = 4'(BLOCK_LEN);

    state_e                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    sat_q, sat_d;
    logic signed [ACC_W-1:0] out_data_q, out_data_d;
    logic [3:0]              out_count_q, out_count_d;
    logic                    out_sat_q, out_sat_d;

    logic                    in_xfer;
    logic                    out_xfer;
    logic [ACC_W-1:0]        in_sext;
    logic [ACC_W:0]          sum_wide;
    logic                    add_ovf;
    logic [ACC_W-1:0]        acc_next_sat;

    // in_ready/out_valid depend on state only, so no combinational path runs
    // from the input handshake to the output handshake.
    assign bus.in_ready  = (state_q != S_HOLD);
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
    assign dbg_state     = state_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    assign in_sext  = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};

    // One guard bit on the add: overflow shows up as the top two bits of the
    // wide sum disagreeing; the guard bit then tells the direction.
    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {in_sext[ACC_W-1], in_sext};
    assign add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

    always_comb begin
        acc_next_sat = sum_wide[ACC_W-1:0];
        if (add_ovf) begin
            acc_next_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_IDLE: begin
                // A flush without a sample has no block to close here.
                if (in_xfer) begin
                    acc_d   = in_sext;
                    cnt_d   = 4'd1;
                    sat_d   = 1'b0;
                    state_d = bus.flush ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (in_xfer) begin
                    acc_d = acc_next_sat;
                    cnt_d = cnt_q + 4'd1;
                    sat_d = sat_q | add_ovf;
                    if ((cnt_d == BLOCK_LEN_C) || bus.flush) begin
                        state_d = S_HOLD;
                    end
                end else if (bus.flush) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_xfer) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    sat_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = 4'd0;
                sat_d   = 1'b0;
            end
        endcase

        // Capture the block result on the way into HOLD, including the
        // sample taken on the closing edge.
        if ((state_d == S_HOLD) && (state_q != S_HOLD)) begin
            out_data_d  = acc_d;
            out_count_d = cnt_d;
            out_sat_d   = sat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= 4'd0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= 4'd0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_alu_result_accum.sv
// ----------------------------------------------------------------------------
// tb_alu_result_accum
//   Directed cases for the documented scenarios followed by randomized
//   traffic. A block-level model (list of accepted samples, stepwise clamped
//   integer sum) predicts every held block sum and handshake level.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_result_accum;
    localparam int IN_W      = 16;
    localparam int ACC_W     = 18;
    localparam int BLOCK_LEN = 8;
    localparam int EW        = ACC_W + 5;
    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_result_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

    alu_result_accum #(
        .IN_W(IN_W), .ACC_W(ACC_W), .BLOCK_LEN(BLOCK_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // exp_q entries: {sat, count[3:0], data[ACC_W-1:0]}
    logic [EW-1:0] exp_q[$];
    int            cur[$];
    bit            m_hold = 1'b0;

    function automatic logic [EW-1:0] close_block();
        longint acc = 0;
        bit     s   = 1'b0;
        foreach (cur[i]) begin
            acc += cur[i];
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                s   = 1'b1;
            end else if (acc < ACC_MIN) begin
                acc = ACC_MIN;
                s   = 1'b1;
            end
        end
        return {s, 4'(cur.size()), ACC_W'(acc)};
    endfunction

    // Observe in the middle of each cycle, then advance the model by what the
    // coming rising edge will do with the inputs currently applied.
    always @(negedge clk) begin
        if (!rst) begin
            cur.delete();
            exp_q.delete();
            m_hold = 1'b0;
            chk("rst_out_valid", longint'(bus.out_valid), 0);
            chk("rst_in_ready",  longint'(bus.in_ready),  1);
            chk("rst_out_data",  longint'(bus.out_data),  0);
            chk("rst_out_count", longint'(bus.out_count), 0);
            chk("rst_out_sat",   longint'(bus.out_sat),   0);
        end else begin
            chk("in_ready",  longint'(bus.in_ready),  longint'(!m_hold));
            chk("out_valid", longint'(bus.out_valid), longint'(m_hold));
            if (m_hold && exp_q.size() > 0) begin
                chk("out_data",  longint'(bus.out_data),
                    longint'($signed(exp_q[0][ACC_W-1:0])));
                chk("out_count", longint'(bus.out_count), longint'(exp_q[0][ACC_W+3:ACC_W]));
                chk("out_sat",   longint'(bus.out_sat),   longint'(exp_q[0][ACC_W+4]));
            end
            if (m_hold) begin
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    m_hold = 1'b0;
                end
            end else begin
                if (bus.in_valid) cur.push_back(int'(bus.in_data));
                if ((cur.size() > 0) &&
                    ((cur.size() == BLOCK_LEN) || bus.flush)) begin
                    exp_q.push_back(close_block());
                    cur.delete();
                    m_hold = 1'b1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one sample until it is accepted (bounded wait).
    task automatic send(input int d, input bit f);
        int waited = 0;
        bit done   = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(d);
        bus.flush    = f;
        while (!done) begin
            done = bus.in_ready;
            @(posedge clk);
            #1;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    chk("send_timeout", 1, 0);
                    done = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic send_n(input int n, input int d);
        for (int i = 0; i < n; i++) send(d, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // full blocks, out_ready held high
        send_n(8, 1000);
        idle(2);
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 300 : -500, 1'b0);
        idle(2);
        send_n(8, 32767);
        idle(2);
        send_n(8, -32768);
        idle(2);

        // flush with the third sample, then a lone flush in idle
        send(7, 1'b0);
        send(7, 1'b0);
        send(7, 1'b1);
        idle(2);
        bus.flush = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(2);

        // flush without a sample while accumulating
        send(-40, 1'b0);
        send(15, 1'b0);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // back-pressure: hold the sum while a sample is pending
        bus.out_ready = 1'b0;
        send_n(8, 250);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(123);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(9, 1'b1);
        idle(2);

        // reset in the middle of a block
        send_n(4, 5);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", longint'(bus.out_valid), 0);
        chk("midrst_in_ready",  longint'(bus.in_ready),  1);
        chk("midrst_out_data",  longint'(bus.out_data),  0);
        chk("midrst_out_count", longint'(bus.out_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);
        send_n(8, 1);
        idle(2);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.in_data = 16'sh7fff;
                1:       bus.in_data = 16'sh8000;
                default: bus.in_data = 16'($urandom);
            endcase
            bus.flush     = ($urandom_range(0, 9) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end

        bus.out_ready = 1'b1;
        idle(4);
        chk("drain_empty", longint'(exp_q.size()), 0);
        chk("drain_no_hold", longint'(m_hold), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        chk("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
